// File: rtl/vga_sync_rx.sv
// VGA receive front-end: recovers h/v counters from HS/VS, checks sync timing,
// locks after clean frames and emits active-pixel coordinates with colour.
module vga_sync_rx #(
  parameter int C_H_Sync_Pulse  = 112,
  parameter int C_H_Back_Porch  = 248,
  parameter int C_H_Active_Time = 1280,
  parameter int C_H_Line_Period = 1688,
  parameter int C_V_Sync_Pulse  = 3,
  parameter int C_V_Back_Porch  = 38,
  parameter int C_V_Active_Time = 1024,
  parameter int C_V_Line_Period = 1066,
  parameter int C_Lock_Frames   = 2,
  parameter int C_Timeout       = 3376
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_hs,
  input  logic        I_vs,
  input  logic [3:0]  I_red,
  input  logic [3:0]  I_green,
  input  logic [3:0]  I_blue,
  output logic        O_de,
  output logic [10:0] O_x,
  output logic [10:0] O_y,
  output logic [3:0]  O_red,
  output logic [3:0]  O_green,
  output logic [3:0]  O_blue,
  output logic        O_locked,
  output logic        O_err,
  output logic        O_frame_start,
  output logic [11:0] O_line_len,
  output logic [11:0] O_frame_lines
);

  localparam int GW = $clog2(C_Lock_Frames + 1);

  localparam logic [11:0] H_ACT_LO = 12'(C_H_Sync_Pulse + C_H_Back_Porch);
  localparam logic [11:0] H_ACT_HI = 12'(C_H_Sync_Pulse + C_H_Back_Porch + C_H_Active_Time - 1);
  localparam logic [11:0] V_ACT_LO = 12'(C_V_Sync_Pulse + C_V_Back_Porch);
  localparam logic [11:0] V_ACT_HI = 12'(C_V_Sync_Pulse + C_V_Back_Porch + C_V_Active_Time - 1);
  localparam logic [12:0] H_PER    = 13'(C_H_Line_Period);
  localparam logic [12:0] H_SYNC   = 13'(C_H_Sync_Pulse);
  localparam logic [12:0] V_PER    = 13'(C_V_Line_Period);
  localparam logic [11:0] TIMEOUT  = 12'(C_Timeout);
  localparam logic [GW-1:0] LOCK_N = GW'(C_Lock_Frames);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // stage 1
  logic        r_hs, r_vs;
  logic [11:0] r_rgb;
  logic [11:0] h_cnt, v_cnt;

  state_t      state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic        dirty_q, dirty_d;
  logic        err_d;

  logic        hs_fall, hs_rise, vs_fall;
  logic [11:0] h_inc, v_inc;
  logic        line_bad, width_bad, frame_bad, timing_bad, timeout;
  logic [GW-1:0] good_inc;
  logic        h_act, v_act, de_s1;
  logic [1:0]  fs_pipe;

  assign hs_fall = !I_hs && r_hs;
  assign hs_rise = I_hs && !r_hs;
  assign vs_fall = !I_vs && r_vs;

  assign h_inc = (&h_cnt) ? h_cnt : h_cnt + 12'd1;
  assign v_inc = (&v_cnt) ? v_cnt : v_cnt + 12'd1;

  // Measurements are one wider than the counters so a saturated count
  // can never alias onto a legal period.
  assign line_bad   = hs_fall && (({1'b0, h_cnt} + 13'd1) != H_PER);
  assign width_bad  = hs_rise && (({1'b0, h_cnt} + 13'd1) != H_SYNC);
  assign frame_bad  = vs_fall && (({1'b0, v_cnt} + 13'd1) != V_PER);
  assign timing_bad = line_bad || width_bad || frame_bad;
  assign timeout    = (h_cnt == TIMEOUT);
  assign good_inc   = good_q + GW'(1);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hs  <= I_hs;
      r_vs  <= I_vs;
      r_rgb <= {I_red, I_green, I_blue};
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      O_line_len    <= '0;
      O_frame_lines <= '0;
    end else begin
      h_cnt <= hs_fall ? 12'd0 : h_inc;
      if (vs_fall)      v_cnt <= 12'd0;
      else if (hs_fall) v_cnt <= v_inc;
      if (hs_fall) O_line_len    <= h_inc;
      if (vs_fall) O_frame_lines <= v_inc;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      dirty_q  <= 1'b0;
      O_err    <= 1'b0;
      O_locked <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      dirty_q  <= dirty_d;
      O_err    <= err_d;
      O_locked <= (state_q == LOCKED);
    end
  end

  // dirty marks a frame that saw an error; it is cleared at each VS fall so
  // the next frame starts clean even when the error landed on the VS edge.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    dirty_d = dirty_q;
    err_d   = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      good_d  = '0;
      dirty_d = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (vs_fall) begin
            state_d = ACQ;
            good_d  = '0;
            dirty_d = 1'b0;
          end
        end
        ACQ: begin
          if (timing_bad) begin
            err_d   = 1'b1;
            good_d  = '0;
            dirty_d = !vs_fall;
          end else if (vs_fall) begin
            dirty_d = 1'b0;
            if (!dirty_q) begin
              good_d = good_inc;
              if (good_inc == LOCK_N) state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (timing_bad) begin
            err_d   = 1'b1;
            state_d = ACQ;
            good_d  = '0;
            dirty_d = !vs_fall;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign h_act = (h_cnt >= H_ACT_LO) && (h_cnt <= H_ACT_HI);
  assign v_act = (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_HI);
  assign de_s1 = h_act && v_act && (state_q == LOCKED);

  // stage 2
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_de    <= 1'b0;
      O_x     <= '0;
      O_y     <= '0;
      O_red   <= '0;
      O_green <= '0;
      O_blue  <= '0;
      fs_pipe <= '0;
    end else begin
      O_de    <= de_s1;
      O_x     <= de_s1 ? 11'(h_cnt - H_ACT_LO) : 11'd0;
      O_y     <= de_s1 ? 11'(v_cnt - V_ACT_LO) : 11'd0;
      O_red   <= de_s1 ? r_rgb[11:8] : 4'd0;
      O_green <= de_s1 ? r_rgb[7:4]  : 4'd0;
      O_blue  <= de_s1 ? r_rgb[3:0]  : 4'd0;
      fs_pipe <= {fs_pipe[0], vs_fall && (state_q == LOCKED)};
    end
  end

  assign O_frame_start = fs_pipe[1];

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a scaled-down raster (24x10 total) so
// every lock/unlock scenario fits in a few thousand clocks.
module tb_vga_sync_rx;
  localparam int HSP = 4, HBP = 6, HACT = 8, HPER = 24;
  localparam int VSP = 2, VBP = 2, VACT = 4, VPER = 10;
  localparam int TO = 48, LOCKF = 2;

  logic        I_clk = 1'b0, I_rst_n = 1'b0, I_hs = 1'b1, I_vs = 1'b1;
  logic [3:0]  I_red = '0, I_green = '0, I_blue = '0;
  logic        O_de, O_locked, O_err, O_frame_start;
  logic [10:0] O_x, O_y;
  logic [3:0]  O_red, O_green, O_blue;
  logic [11:0] O_line_len, O_frame_lines;

  vga_sync_rx #(
    .C_H_Sync_Pulse(HSP), .C_H_Back_Porch(HBP), .C_H_Active_Time(HACT),
    .C_H_Line_Period(HPER), .C_V_Sync_Pulse(VSP), .C_V_Back_Porch(VBP),
    .C_V_Active_Time(VACT), .C_V_Line_Period(VPER), .C_Lock_Frames(LOCKF),
    .C_Timeout(TO)
  ) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_hs(I_hs), .I_vs(I_vs),
    .I_red(I_red), .I_green(I_green), .I_blue(I_blue),
    .O_de(O_de), .O_x(O_x), .O_y(O_y),
    .O_red(O_red), .O_green(O_green), .O_blue(O_blue),
    .O_locked(O_locked), .O_err(O_err), .O_frame_start(O_frame_start),
    .O_line_len(O_line_len), .O_frame_lines(O_frame_lines)
  );

  always #5 I_clk = ~I_clk;

  int gen_h, gen_v, cur_hper, cur_hsp;
  int errors, checks, err_cnt, fs_cnt, de_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int h, input int v);
    if (h == HSP + HBP && v == VSP + VBP) return 12'hF00;
    return {4'(h), 4'(v), 4'hA};
  endfunction

  task automatic sample();
    @(posedge I_clk);
    #1;
    if (O_err) err_cnt++;
    if (O_frame_start) fs_cnt++;
    if (O_de) de_cnt++;
  endtask

  // Generator: h=0 is HS fall, line 0 is VS fall; one-line overrides of
  // period/width revert at the end of the line.
  task automatic tick();
    I_hs = (gen_h >= cur_hsp);
    I_vs = (gen_v >= VSP);
    {I_red, I_green, I_blue} = pix(gen_h, gen_v);
    sample();
    if (gen_h == cur_hper - 1) begin
      gen_h    = 0;
      cur_hper = HPER;
      cur_hsp  = HSP;
      gen_v    = (gen_v == VPER - 1) ? 0 : gen_v + 1;
    end else begin
      gen_h++;
    end
  endtask

  task automatic idle_tick();
    I_hs = 1'b1;
    I_vs = 1'b1;
    {I_red, I_green, I_blue} = '0;
    sample();
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 2 * HPER * VPER && !(gen_h == h && gen_v == v); i++) tick();
  endtask

  task automatic vs_tick();
    run_to(0, 0);
    tick();
  endtask

  initial begin
    errors = 0; checks = 0; err_cnt = 0; fs_cnt = 0; de_cnt = 0;
    gen_h = 0; gen_v = 5; cur_hper = HPER; cur_hsp = HSP;

    repeat (3) idle_tick();
    chk("rst_de", O_de, 0);
    chk("rst_locked", O_locked, 0);
    chk("rst_line_len", O_line_len, 0);
    chk("rst_frame_lines", O_frame_lines, 0);
    chk("rst_x", O_x, 0);
    #2;
    I_rst_n = 1'b1;

    // initial acquisition: lock 2 clocks after the 3rd VS fall
    vs_tick(); vs_tick(); tick();
    chk("lock_after_2vs", O_locked, 0);
    vs_tick();
    chk("lock_edge1", O_locked, 0);
    tick();
    chk("lock_edge2", O_locked, 1);
    chk("nom_line_len", O_line_len, HPER);
    chk("nom_frame_lines", O_frame_lines, VPER);
    chk("nom_no_err", err_cnt, 0);
    vs_tick();
    chk("fs_edge1", O_frame_start, 0);
    tick();
    chk("fs_edge2", O_frame_start, 1);
    chk("fs_count", fs_cnt, 1);

    // active window and latency
    run_to(10, 4); tick();
    chk("de_lat1", O_de, 0);
    tick();
    chk("de_first", O_de, 1);
    chk("x_first", O_x, 0);
    chk("y_first", O_y, 0);
    chk("red_first", O_red, 4'hF);
    chk("green_first", O_green, 0);
    chk("blue_first", O_blue, 0);
    tick();
    chk("x_second", O_x, 1);
    chk("rgb_second", {O_red, O_green, O_blue}, 12'hB4A);
    run_to(17, 4); tick(); tick();
    chk("de_last_col", O_de, 1);
    chk("x_last_col", O_x, 7);
    tick();
    chk("de_past_col", O_de, 0);
    chk("x_past_col", O_x, 0);
    chk("red_past_col", O_red, 0);
    run_to(12, 7); tick(); tick();
    chk("de_last_row", O_de, 1);
    chk("xy_last_row", {O_x, O_y}, {11'd2, 11'd3});
    run_to(10, 8); tick(); tick();
    chk("de_past_row", O_de, 0);
    chk("y_past_row", O_y, 0);

    // shortened line while locked
    run_to(0, 5);
    cur_hper = HPER - 1;
    run_to(0, 6); tick();
    chk("short_err", O_err, 1);
    chk("short_line_len", O_line_len, HPER - 1);
    chk("short_locked_hold", O_locked, 1);
    tick();
    chk("short_unlock", O_locked, 0);
    chk("short_err_1cyc", O_err, 0);
    run_to(0, 7); tick();
    chk("short_len_restored", O_line_len, HPER);
    vs_tick(); tick();
    chk("short_dirty_frame", O_locked, 0);
    vs_tick(); tick();
    chk("short_one_clean", O_locked, 0);
    vs_tick(); tick();
    chk("short_relock", O_locked, 1);
    chk("short_err_count", err_cnt, 1);

    // narrow HS pulse
    run_to(0, 5);
    cur_hsp = HSP - 1;
    run_to(3, 5); tick();
    chk("width_err", O_err, 1);
    tick();
    chk("width_unlock", O_locked, 0);
    vs_tick(); tick();
    chk("width_dirty_frame", O_locked, 0);
    vs_tick(); tick();
    chk("width_one_clean", O_locked, 0);
    vs_tick(); tick();
    chk("width_relock", O_locked, 1);
    chk("width_err_count", err_cnt, 2);

    // HS stuck high: timeout to SEARCH without error
    run_to(0, 5);
    for (int k = 1; k <= 100; k++) begin
      idle_tick();
      if (k == TO - 22) chk("to_locked_hold", O_locked, 1);
      if (k == TO - 21) chk("to_unlock", O_locked, 0);
    end
    chk("to_no_err", err_cnt, 2);
    tick();
    chk("to_resume_len", O_line_len, 124);
    vs_tick(); tick();
    chk("to_acq1", O_locked, 0);
    vs_tick(); tick();
    chk("to_acq2", O_locked, 0);
    vs_tick(); tick();
    chk("to_relock", O_locked, 1);
    chk("to_err_count", err_cnt, 2);

    // asynchronous reset mid-frame
    run_to(12, 5); tick(); tick();
    chk("pre_rst_de", O_de, 1);
    chk("pre_rst_pix", {O_x, O_y, O_red}, {11'd2, 11'd1, 4'hC});
    #2;
    I_rst_n = 1'b0;
    #1;
    chk("arst_de", O_de, 0);
    chk("arst_xy", {O_x, O_y}, 0);
    chk("arst_rgb", {O_red, O_green, O_blue}, 0);
    chk("arst_locked", O_locked, 0);
    chk("arst_lens", {O_line_len, O_frame_lines}, 0);
    tick(); tick();
    #2;
    I_rst_n = 1'b1;
    de_cnt = 0;
    vs_tick(); vs_tick(); vs_tick(); tick();
    chk("arst_no_de_before_lock", de_cnt, 0);
    chk("arst_relock", O_locked, 1);
    de_cnt = 0;
    run_to(0, 0);
    chk("arst_full_frame_de", de_cnt, HACT * VACT);
    chk("final_err_count", err_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
